// File: rtl/anti_theft_pkg.sv
// ----------------------------------------------------------------------------
// anti_theft_pkg
// Shared definitions for the vehicle anti-theft controller:
//   - state_t      : alarm FSM state encodings (0..6, 7 is illegal)
//   - SEL_*        : time parameter index values for time_param_sel
//   - DEF_*        : power-on / reset values of the time parameters (seconds)
// ----------------------------------------------------------------------------
package anti_theft_pkg;

    typedef enum logic [2:0] {
        ST_ARMED      = 3'd0,
        ST_TRIGGERED  = 3'd1,
        ST_ALARM      = 3'd2,
        ST_DISARMED   = 3'd3,
        ST_WAIT_OPEN  = 3'd4,
        ST_WAIT_CLOSE = 3'd5,
        ST_ARM_DELAY  = 3'd6
    } state_t;

    localparam logic [1:0] SEL_T_ARM    = 2'd0;
    localparam logic [1:0] SEL_T_DRIVER = 2'd1;
    localparam logic [1:0] SEL_T_PASS   = 2'd2;
    localparam logic [1:0] SEL_T_ALARM  = 2'd3;

    localparam logic [3:0] DEF_T_ARM    = 4'd6;
    localparam logic [3:0] DEF_T_DRIVER = 4'd8;
    localparam logic [3:0] DEF_T_PASS   = 4'd15;
    localparam logic [3:0] DEF_T_ALARM  = 4'd10;

endpackage

// File: rtl/anti_theft_fsm_one_hz_tick.sv
// ----------------------------------------------------------------------------
// one_hz_tick
// Free-running timebase: produces a one-cycle tick every CLK_HZ clocks.
// The phase can be restarted with clear so that a freshly started delay
// always gets full one-second periods.
// Ports:
//   clock  in  system clock
//   reset  in  synchronous, active-high
//   clear  in  restart the period count from zero on the next edge
//   tick   out one-cycle pulse, high during the last cycle of each period
// ----------------------------------------------------------------------------
module one_hz_tick #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/anti_theft_fsm.sv
// ----------------------------------------------------------------------------
// anti_theft_fsm
// Vehicle anti-theft controller. Takes debounced, synchronous switch levels
// and drives the status LED, siren and fuel-pump enable.
// Ports:
//   clock, reset    system clock, synchronous active-high reset
//   ignition        1 = ignition on
//   door_driver     1 = driver door open
//   door_pass       1 = passenger door open
//   hidden_sw       hidden switch
//   brake           1 = brake pressed
//   reprogram       reprogram button, acts on its rising edge
//   time_param_sel  parameter to write: 0 T_ARM, 1 T_DRIVER, 2 T_PASS, 3 T_ALARM
//   time_value      new parameter value in seconds
//   status_led      status indicator (blinks while armed)
//   siren           alarm siren
//   fuel_pump       fuel pump enable
//   state_dbg       current FSM state encoding
// ----------------------------------------------------------------------------
module anti_theft_fsm
    import anti_theft_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       hidden_sw,
    input  logic       brake,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    output logic       status_led,
    output logic       siren,
    output logic       fuel_pump,
    output logic [2:0] state_dbg
);

    state_t     state;
    state_t     state_nx;
    logic       reprogram_q;
    logic       rep_edge;
    logic [3:0] t_arm;
    logic [3:0] t_driver;
    logic [3:0] t_pass;
    logic [3:0] t_alarm;
    logic       tm_running;
    logic [3:0] tm_count;
    logic       tm_start;
    logic [3:0] tm_load;
    logic       expired;
    logic       tick;
    logic       led_nx;
    logic       siren_nx;

    assign rep_edge = reprogram & ~reprogram_q;
    assign expired  = tm_running && (tm_count == 4'd0);

    // A timer start or a reprogram restarts the one-second phase.
    one_hz_tick #(
        .CLK_HZ(CLK_HZ)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .clear(tm_start | rep_edge),
        .tick (tick)
    );

    // Stage boundary: parameter registers and reprogram edge detector
    always_ff @(posedge clock) begin
        if (reset) begin
            reprogram_q <= 1'b0;
            t_arm       <= DEF_T_ARM;
            t_driver    <= DEF_T_DRIVER;
            t_pass      <= DEF_T_PASS;
            t_alarm     <= DEF_T_ALARM;
        end else begin
            reprogram_q <= reprogram;
            if (rep_edge) begin
                case (time_param_sel)
                    SEL_T_ARM:    t_arm    <= time_value;
                    SEL_T_DRIVER: t_driver <= time_value;
                    SEL_T_PASS:   t_pass   <= time_value;
                    default:      t_alarm  <= time_value;
                endcase
            end
        end
    end

    // Stage boundary: delay timer (start wins over countdown and expiry)
    always_ff @(posedge clock) begin
        if (reset) begin
            tm_running <= 1'b0;
            tm_count   <= 4'd0;
        end else if (rep_edge) begin
            tm_running <= 1'b0;
        end else if (tm_start) begin
            tm_running <= 1'b1;
            tm_count   <= tm_load;
        end else if (tm_running && tick && (tm_count != 4'd0)) begin
            tm_count <= tm_count - 4'd1;
        end
    end

    // Next-state logic; ignition is tested ahead of doors and expiry.
    always_comb begin
        state_nx = state;
        tm_start = 1'b0;
        tm_load  = 4'd0;
        if (rep_edge) begin
            state_nx = ST_ARMED;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (ignition) begin
                        state_nx = ST_DISARMED;
                    end else if (door_driver) begin
                        state_nx = ST_TRIGGERED;
                        tm_start = 1'b1;
                        tm_load  = t_driver;
                    end else if (door_pass) begin
                        state_nx = ST_TRIGGERED;
                        tm_start = 1'b1;
                        tm_load  = t_pass;
                    end
                end
                ST_TRIGGERED: begin
                    if (ignition) begin
                        state_nx = ST_DISARMED;
                    end else if (expired) begin
                        state_nx = ST_ALARM;
                        tm_start = 1'b1;
                        tm_load  = t_alarm;
                    end
                end
                ST_ALARM: begin
                    if (ignition) begin
                        state_nx = ST_DISARMED;
                    end else if (door_driver || door_pass) begin
                        // An open door keeps the siren going: reload every cycle.
                        tm_start = 1'b1;
                        tm_load  = t_alarm;
                    end else if (expired) begin
                        state_nx = ST_ARMED;
                    end
                end
                ST_DISARMED: begin
                    if (!ignition) begin
                        state_nx = ST_WAIT_OPEN;
                    end
                end
                ST_WAIT_OPEN: begin
                    if (ignition) begin
                        state_nx = ST_DISARMED;
                    end else if (door_driver) begin
                        state_nx = ST_WAIT_CLOSE;
                    end
                end
                ST_WAIT_CLOSE: begin
                    if (ignition) begin
                        state_nx = ST_DISARMED;
                    end else if (!door_driver) begin
                        state_nx = ST_ARM_DELAY;
                        tm_start = 1'b1;
                        tm_load  = t_arm;
                    end
                end
                ST_ARM_DELAY: begin
                    if (ignition) begin
                        state_nx = ST_DISARMED;
                    end else if (door_driver || door_pass) begin
                        state_nx = ST_WAIT_CLOSE;
                    end else if (expired) begin
                        state_nx = ST_ARMED;
                    end
                end
                default: begin
                    state_nx = ST_ARMED;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so they register together
    // with it. The armed blink toggles only while staying in ARMED; a
    // reprogram restarts the timebase, so it never toggles on that edge.
    always_comb begin
        led_nx   = 1'b0;
        siren_nx = (state_nx == ST_ALARM);
        case (state_nx)
            ST_ARMED: begin
                if (state == ST_ARMED) begin
                    led_nx = (tick && !rep_edge) ? ~status_led : status_led;
                end
            end
            ST_TRIGGERED: led_nx = 1'b1;
            ST_ALARM:     led_nx = 1'b1;
            default:      led_nx = 1'b0;
        endcase
    end

    // Stage boundary: FSM state and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_ARMED;
            status_led <= 1'b0;
            siren      <= 1'b0;
        end else begin
            state      <= state_nx;
            status_led <= led_nx;
            siren      <= siren_nx;
        end
    end

    // Stage boundary: fuel-pump interlock, independent of the alarm FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            fuel_pump <= 1'b0;
        end else if (ignition && hidden_sw && brake) begin
            fuel_pump <= 1'b1;
        end else if (!ignition) begin
            fuel_pump <= 1'b0;
        end
    end

    assign state_dbg = state;

endmodule
